// File: rtl/motor_cmd_decoder.sv
// Motor command decoder: turns SPI header/data word pairs into per-channel
// step divider, direction and enable registers, and returns the position of the selected channel.
module motor_cmd_decoder #(
  parameter int NUM_MOTORS  = 7,
  parameter int DIV_W       = 13,
  parameter int POS_W       = 20,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [15:0]                 rx_data,
  input  logic                        word_received,
  input  logic [NUM_MOTORS*POS_W-1:0] cur_position,
  output logic [NUM_MOTORS*DIV_W-1:0] divider,
  output logic [NUM_MOTORS-1:0]       move_dir,
  output logic [NUM_MOTORS-1:0]       step_ena,
  output logic [15:0]                 tx_word,
  output logic                        busy,
  output logic [7:0]                  err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [3:0] NM = 4'(NUM_MOTORS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {
    IDLE,
    WAIT_DATA
  } state_t;

  state_t state_q, state_d;
  logic wr_q, wr_d;
  logic [3:0] sel_q, sel_d;
  logic pend_dir_q, pend_dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [NUM_MOTORS*DIV_W-1:0] div_q, div_d;
  logic [NUM_MOTORS-1:0] dir_q, dir_d;
  logic [NUM_MOTORS-1:0] ena_q, ena_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0] err_q, err_d;

  logic accept;
  logic [3:0] idx;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic [POS_W-1:0] pos_sel;
  logic unused_bits;

  assign unused_bits = ^{rx_data, cur_position};

  assign accept = word_received & ~wr_q;
  assign idx    = rx_data[3:0];

  // Pick the selected channel's position for the SPI return word
  always_comb begin
    pos_sel = '0;
    for (int k = 0; k < NUM_MOTORS; k++) begin
      if (sel_q == 4'(k)) pos_sel = cur_position[k*POS_W +: POS_W];
    end
  end

  // Protocol FSM, channel register writes and error accounting
  always_comb begin
    state_d    = state_q;
    wr_d       = word_received;
    sel_d      = sel_q;
    pend_dir_d = pend_dir_q;
    timer_d    = timer_q;
    div_d      = div_q;
    dir_d      = dir_q;
    ena_d      = ena_q;
    tx_d       = pos_sel[18:3];
    err_inc    = 2'd0;
    if (accept) begin
      if (rx_data[15]) begin
        if (state_q == WAIT_DATA) begin
          for (int k = 0; k < NUM_MOTORS; k++) begin
            if (sel_q == 4'(k)) begin
              div_d[k*DIV_W +: DIV_W] = rx_data[DIV_W-1:0];
              dir_d[k] = pend_dir_q;
              ena_d[k] = rx_data[13];
            end
          end
          state_d = IDLE;
        end else begin
          err_inc = 2'd1;
        end
      end else begin
        if (state_q == WAIT_DATA) err_inc = 2'd1;
        if (idx < NM) begin
          sel_d      = idx;
          pend_dir_d = rx_data[4];
          timer_d    = '0;
          state_d    = WAIT_DATA;
        end else if (idx == 4'hF) begin
          ena_d   = '0;
          state_d = IDLE;
        end else begin
          err_inc = err_inc + 2'd1;
          state_d = IDLE;
        end
      end
    end else if (state_q == WAIT_DATA) begin
      if (timer_q == TLAST) begin
        state_d = IDLE;
        timer_d = '0;
        err_inc = 2'd1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
    err_sum = {1'b0, err_q} + {7'd0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // State registers; wr_q resets high so a held word is not taken as new
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b1;
      sel_q      <= '0;
      pend_dir_q <= 1'b0;
      timer_q    <= '0;
      div_q      <= '0;
      dir_q      <= '0;
      ena_q      <= '0;
      tx_q       <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      sel_q      <= sel_d;
      pend_dir_q <= pend_dir_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      dir_q      <= dir_d;
      ena_q      <= ena_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
    end
  end

  assign divider  = div_q;
  assign move_dir = dir_q;
  assign step_ena = ena_q;
  assign tx_word  = tx_q;
  assign busy     = (state_q == WAIT_DATA);
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_motor_cmd_decoder.sv
// Scoreboard bench for motor_cmd_decoder: stimulus queues expected
// register snapshots, a negedge monitor pops and compares them.
module tb_motor_cmd_decoder;

  localparam int NM = 7;
  localparam int DW = 13;
  localparam int PW = 20;
  localparam int TO = 40;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic [15:0] rx_data = '0;
  logic word_received = 1'b0;
  logic [NM*PW-1:0] cur_position = '0;
  logic [NM*DW-1:0] divider;
  logic [NM-1:0] move_dir;
  logic [NM-1:0] step_ena;
  logic [15:0] tx_word;
  logic busy;
  logic [7:0] err_cnt;

  motor_cmd_decoder #(
    .NUM_MOTORS(NM),
    .DIV_W(DW),
    .POS_W(PW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .rx_data(rx_data),
    .word_received(word_received),
    .cur_position(cur_position),
    .divider(divider),
    .move_dir(move_dir),
    .step_ena(step_ena),
    .tx_word(tx_word),
    .busy(busy),
    .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int when;
    string name;
    logic [NM*DW-1:0] div;
    logic [NM-1:0] dir;
    logic [NM-1:0] ena;
    logic busy;
    logic [7:0] err;
    logic [15:0] tx;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  int ncyc = 0;

  logic [NM*DW-1:0] e_div = '0;
  logic [NM-1:0] e_dir = '0;
  logic [NM-1:0] e_ena = '0;
  logic e_busy = 1'b0;
  logic [7:0] e_err = '0;
  logic [15:0] e_tx = '0;

  task automatic push(input int dly, input string nm);
    exp_t e;
    e.when = ncyc + dly;
    e.name = nm;
    e.div  = e_div;
    e.dir  = e_dir;
    e.ena  = e_ena;
    e.busy = e_busy;
    e.err  = e_err;
    e.tx   = e_tx;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [15:0] w);
    rx_data = w;
    word_received = 1'b1;
    @(posedge CLK); #1;
    word_received = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  // Monitor: compare the DUT against every snapshot due at this negedge
  initial begin
    forever begin
      @(negedge CLK);
      ncyc++;
      while (sbq.size() > 0 && sbq[0].when <= ncyc) begin
        cur = sbq.pop_front();
        checks++;
        if (cur.when < ncyc) begin
          errors++;
          $display("FAIL %s stale: due %0d now %0d", cur.name, cur.when, ncyc);
        end else if (divider !== cur.div || move_dir !== cur.dir ||
                     step_ena !== cur.ena || busy !== cur.busy ||
                     err_cnt !== cur.err || tx_word !== cur.tx) begin
          errors++;
          $display("FAIL %s got div=%h dir=%b ena=%b busy=%b err=%0d tx=%h want div=%h dir=%b ena=%b busy=%b err=%0d tx=%h",
                   cur.name, divider, move_dir, step_ena, busy, err_cnt, tx_word,
                   cur.div, cur.dir, cur.ena, cur.busy, cur.err, cur.tx);
        end
      end
    end
  end

  initial begin
    idle(2);
    push(1, "reset");
    idle(2);
    reset = 1'b0;
    idle(2);

    e_busy = 1'b1;
    push(2, "hdr_ch3");
    send(16'h0013);
    e_div[3*DW +: DW] = 13'h0123;
    e_dir[3] = 1'b1;
    e_ena[3] = 1'b1;
    e_busy = 1'b0;
    push(2, "data_ch3");
    send(16'hA123);

    e_err = 8'd1;
    push(2, "data_in_idle");
    send(16'h8100);
    e_err = 8'd2;
    push(2, "bad_index");
    send(16'h000A);

    e_busy = 1'b1;
    push(2, "hdr_ch0");
    send(16'h0000);
    e_div[0 +: DW] = 13'h07FF;
    e_ena[0] = 1'b1;
    e_busy = 1'b0;
    push(2, "data_ch0");
    send(16'hA7FF);
    e_busy = 1'b1;
    push(2, "hdr_ch2");
    send(16'h0012);
    e_div[2*DW +: DW] = 13'h1FFF;
    e_dir[2] = 1'b1;
    e_ena[2] = 1'b1;
    e_busy = 1'b0;
    push(2, "data_ch2_max");
    send(16'hBFFF);
    e_ena = '0;
    push(2, "bcast_stop");
    send(16'h000F);

    e_busy = 1'b1;
    push(2, "hdr_timeout");
    push(TO + 1, "before_timeout");
    e_busy = 1'b0;
    e_err = 8'd3;
    push(TO + 2, "timeout");
    send(16'h0002);
    idle(TO);
    e_err = 8'd4;
    push(2, "late_data");
    send(16'hA010);

    e_busy = 1'b1;
    push(2, "hdr_ch1");
    send(16'h0001);
    e_err = 8'd5;
    push(2, "hdr_in_wait");
    send(16'h0014);
    e_div[4*DW +: DW] = 13'h0055;
    e_dir[4] = 1'b1;
    e_ena[4] = 1'b1;
    e_busy = 1'b0;
    push(2, "data_ch4");
    send(16'hA055);
    e_busy = 1'b1;
    push(2, "hdr_ch5");
    send(16'h0005);
    e_ena = '0;
    e_err = 8'd6;
    e_busy = 1'b0;
    push(2, "bcast_in_wait");
    send(16'h000F);
    e_busy = 1'b1;
    push(2, "hdr_ch3b");
    send(16'h0003);
    e_err = 8'd8;
    e_busy = 1'b0;
    push(2, "bad_idx_in_wait");
    send(16'h0009);
    e_err = 8'd9;
    push(2, "data_after_drop");
    send(16'hA001);

    e_busy = 1'b1;
    push(2, "hdr_ch6");
    send(16'h0006);
    idle(TO - 2);
    e_div[6*DW +: DW] = 13'h00AA;
    e_ena[6] = 1'b1;
    e_busy = 1'b0;
    push(2, "accept_at_timeout");
    send(16'hA0AA);

    cur_position[PW +: PW] = 20'h12345;
    e_busy = 1'b1;
    push(2, "tx_lag");
    e_tx = 16'h2468;
    push(3, "tx_ch1");
    send(16'h0001);
    cur_position[PW +: PW] = 20'h00008;
    e_tx = 16'h0001;
    push(2, "tx_follow");
    idle(2);

    rx_data = 16'h8000;
    word_received = 1'b1;
    reset = 1'b1;
    cur_position = '0;
    e_div = '0;
    e_dir = '0;
    e_ena = '0;
    e_busy = 1'b0;
    e_err = '0;
    e_tx = '0;
    push(1, "reset_in_wait");
    idle(2);
    reset = 1'b0;
    push(2, "release_held");
    idle(2);
    word_received = 1'b0;
    idle(1);
    for (int i = 1; i <= 300; i++) begin
      e_err = (i > 255) ? 8'd255 : 8'(i);
      push(2, (i == 1) ? "pending_dropped" : "err_sat");
      send(16'h8000);
    end

    for (int i = 0; i < 20 && sbq.size() > 0; i++) idle(1);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d left, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
